// File: rtl/ag_ps2_rx.sv
// Event FIFO for the PS/2 receiver: circular buffer with a head-of-queue view.
// Latency: a pushed entry is visible at the head one clk after the push edge.
// Backpressure: a push into a full FIFO is dropped and flagged, unless a pop happens in the same cycle.
module ag_ps2_rx_fifo #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    output logic             drop
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  do_pop;
    logic                  do_push;

    // Count can only reach DEPTH, so its MSB alone marks a full buffer.
    assign full    = count[DEPTH_LOG2];
    assign out_vld = (count != '0);
    assign do_pop  = pop_rdy & out_vld;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign do_push = push_vld & (~full | do_pop);
    assign drop    = push_vld & full & ~do_pop;
    assign out_dat = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// PS/2 device-to-host receiver: frames 11-bit words, checks parity/stop, folds E0/F0 prefixes into flags.
// Latency: key event pushed one clk after the edge that registers PS/2 clock low on the stop bit.
// Backpressure: none toward the keyboard; a full FIFO drops the new event and sets sticky ovf.
module ag_ps2_rx #(
    parameter int TIMEOUT    = 2000,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ps2_bus,
    input  logic       ack,
    input  logic       clr_err,
    output logic       valid,
    output logic [7:0] code,
    output logic       ext,
    output logic       brk,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    // Input stage and edge detection
    logic c_q;
    logic c_p;
    logic d_q;
    logic fall;

    // Frame assembly
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          ext_pend;
    logic          brk_pend;

    // Frame completion decode
    logic     stop_evt;
    logic     par_ok;
    logic     bad_par;
    logic     bad_stop;
    logic     byte_ok;
    logic     is_prefix;
    logic     timeout;
    logic     evt_push;
    key_evt_t evt;
    key_evt_t head;
    logic     fifo_drop;

    // Register the asynchronous bus once, and the clock line a second time for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q <= 1'b1;
            c_p <= 1'b1;
            d_q <= 1'b1;
        end else begin
            c_q <= ps2_bus[0];
            d_q <= ps2_bus[1];
            c_p <= c_q;
        end
    end

    assign fall = c_p & ~c_q;

    // The stop bit is evaluated in the same cycle it is sampled so the push lands one edge later.
    assign stop_evt  = fall && (state == S_STOP);
    // Odd parity: the nine bits together must hold an odd number of ones.
    assign par_ok    = ^{shreg, par_bit};
    assign bad_par   = stop_evt & ~par_ok;
    assign bad_stop  = stop_evt & par_ok & ~d_q;
    assign byte_ok   = stop_evt & par_ok & d_q;
    assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
    // A fall in the same cycle wins over the timeout since it restarts the count anyway.
    assign timeout   = ~fall && (state != S_IDLE) && (to_cnt == TO_LAST);
    assign evt_push  = byte_ok & ~is_prefix;

    assign evt.ext  = ext_pend;
    assign evt.brk  = brk_pend;
    assign evt.code = shreg;

    // Frame FSM with mid-frame timeout, prefix folding and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            to_cnt   <= '0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (fall || (state == S_IDLE)) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timeout) begin
                state <= S_IDLE;
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        // A high data line here is a spurious edge; keep hunting for a start bit.
                        if (!d_q) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {d_q, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= d_q;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end

            // A corrupted frame may have been the key that completes a prefix, so forget pending prefixes.
            if (bad_par || bad_stop || timeout) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end

            perr <= bad_par | (perr & ~clr_err);
            ferr <= bad_stop | timeout | (ferr & ~clr_err);
        end
    end

    // Overflow is sticky and set-dominant over clr_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= fifo_drop | (ovf & ~clr_err);
        end
    end

    ag_ps2_rx_fifo #(
        .WIDTH      ($bits(key_evt_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_evt_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (evt_push),
        .push_dat (evt),
        .pop_rdy  (ack),
        .out_vld  (valid),
        .out_dat  (head),
        .drop     (fifo_drop)
    );

    assign code = head.code;
    assign ext  = head.ext;
    assign brk  = head.brk;
endmodule
